// File: rtl/lap_capture_ctrl.sv
// lap_capture_ctrl
// Lap/split controller for the stopwatch. An accepted lap snapshots the live
// timer value into a small FIFO and freezes the display on that value for
// HOLD_CYCLES cycles. A downstream reader drains the recorded laps over a
// valid/ready handshake. clear_timers empties everything and unfreezes.

module lap_capture_ctrl #(
    parameter int TW          = 12,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 100,
    parameter int HOLD_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       count_en,
    input  logic                       clear_timers,
    input  logic [1:0]                 status,
    input  logic                       lap,
    input  logic [TW-1:0]              time_in,
    output logic [TW-1:0]              disp_time,
    output logic                       disp_frozen,
    output logic                       rd_valid,
    output logic [TW-1:0]              rd_data,
    output logic [3:0]                 rd_idx,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH):0]     lap_count,
    output logic                       buf_full,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [0:0] {
        ST_LIVE   = 1'b0,
        ST_FROZEN = 1'b1
    } state_t;

    // Lap buffer storage and bookkeeping
    logic [TW-1:0] buf_time_r [DEPTH];
    logic [3:0]    buf_idx_r  [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] lap_count_r;
    logic [3:0]    ord_r;
    logic          overflow_r;

    // Display state
    state_t        state_r;
    state_t        state_n;
    logic [TW-1:0] disp_time_r;
    logic [TW-1:0] disp_time_n;
    logic          disp_frozen_r;
    logic          disp_frozen_n;
    logic [HOLD_W-1:0] hold_r;
    logic [HOLD_W-1:0] hold_n;

    // Decoded events
    logic          lap_acc_s;
    logic          full_s;
    logic          valid_s;
    logic          pop_s;
    logic          wr_s;
    logic          drop_s;
    logic [3:0]    ord_nxt_s;

    // A lap only counts while the timer is genuinely running; clear wins over everything
    assign lap_acc_s = lap && (status == 2'b01) && count_en && !clear_timers;
    assign full_s    = (lap_count_r == CW'(DEPTH));
    assign valid_s   = (lap_count_r != {CW{1'b0}});
    assign pop_s     = valid_s && rd_ready && !clear_timers;
    // A full buffer still accepts a lap when the head leaves in the same cycle
    assign wr_s      = lap_acc_s && (!full_s || pop_s);
    assign drop_s    = lap_acc_s && full_s && !pop_s;
    // Ordinal runs 1..15 and never shows 0 once laps have been taken
    assign ord_nxt_s = (ord_r == 4'd15) ? 4'd1 : (ord_r + 4'd1);

    assign disp_time   = disp_time_r;
    assign disp_frozen = disp_frozen_r;
    assign rd_valid    = valid_s;
    assign rd_data     = buf_time_r[rd_ptr_r];
    assign rd_idx      = buf_idx_r[rd_ptr_r];
    assign lap_count   = lap_count_r;
    assign buf_full    = full_s;
    assign overflow    = overflow_r;

    // Buffer entry storage; contents are only visible through rd_valid so no reset is needed
    always_ff @(posedge clk) begin
        if (wr_s) begin
            buf_time_r[wr_ptr_r] <= time_in;
            buf_idx_r[wr_ptr_r]  <= ord_nxt_s;
        end
    end

    // Buffer pointers, occupancy, lap ordinal and sticky overflow flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            lap_count_r <= {CW{1'b0}};
            ord_r       <= 4'd0;
            overflow_r  <= 1'b0;
        end else if (clear_timers) begin
            wr_ptr_r    <= {PW{1'b0}};
            rd_ptr_r    <= {PW{1'b0}};
            lap_count_r <= {CW{1'b0}};
            ord_r       <= 4'd0;
            overflow_r  <= 1'b0;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            if (wr_s && !pop_s) begin
                lap_count_r <= lap_count_r + CW'(1);
            end else if (!wr_s && pop_s) begin
                lap_count_r <= lap_count_r - CW'(1);
            end
            if (lap_acc_s) begin
                ord_r <= ord_nxt_s;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Display FSM state and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_LIVE;
            disp_time_r   <= {TW{1'b0}};
            disp_frozen_r <= 1'b0;
            hold_r        <= {HOLD_W{1'b0}};
        end else begin
            state_r       <= state_n;
            disp_time_r   <= disp_time_n;
            disp_frozen_r <= disp_frozen_n;
            hold_r        <= hold_n;
        end
    end

    // Display FSM next state: live tracking, freeze on lap, timed release
    always_comb begin
        state_n       = state_r;
        disp_time_n   = disp_time_r;
        disp_frozen_n = disp_frozen_r;
        hold_n        = hold_r;
        if (clear_timers) begin
            state_n       = ST_LIVE;
            disp_time_n   = time_in;
            disp_frozen_n = 1'b0;
            hold_n        = {HOLD_W{1'b0}};
        end else begin
            case (state_r)
                ST_LIVE: begin
                    disp_time_n = time_in;
                    if (lap_acc_s) begin
                        state_n       = ST_FROZEN;
                        disp_frozen_n = 1'b1;
                        hold_n        = HOLD_W'(HOLD_CYCLES - 1);
                    end else begin
                        disp_frozen_n = 1'b0;
                    end
                end
                ST_FROZEN: begin
                    if (lap_acc_s) begin
                        // A fresh lap restarts the full hold window
                        disp_time_n   = time_in;
                        disp_frozen_n = 1'b1;
                        hold_n        = HOLD_W'(HOLD_CYCLES - 1);
                    end else if (hold_r == {HOLD_W{1'b0}}) begin
                        state_n       = ST_LIVE;
                        disp_time_n   = time_in;
                        disp_frozen_n = 1'b0;
                    end else begin
                        hold_n = hold_r - HOLD_W'(1);
                    end
                end
                default: begin
                    state_n       = ST_LIVE;
                    disp_time_n   = time_in;
                    disp_frozen_n = 1'b0;
                    hold_n        = {HOLD_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lap_capture_ctrl.sv
// Directed bench for lap_capture_ctrl: table of input/expected records plus
// hand-written sequences for the hold-window timing.

module tb_lap_capture_ctrl;

    logic        clk;
    logic        rst_n;
    logic        count_en;
    logic        clear_timers;
    logic [1:0]  status;
    logic        lap;
    logic [11:0] time_in;
    logic [11:0] disp_time;
    logic        disp_frozen;
    logic        rd_valid;
    logic [11:0] rd_data;
    logic [3:0]  rd_idx;
    logic        rd_ready;
    logic [2:0]  lap_count;
    logic        buf_full;
    logic        overflow;

    int n_vec = 0;
    int n_err = 0;
    int vec_id = 0;

    typedef struct {
        logic        clr;
        logic [1:0]  st;
        logic        cen;
        logic        lp;
        logic [11:0] tin;
        logic        rdy;
        logic        chk_disp;
        logic [11:0] e_disp;
        logic        e_frz;
        logic        e_rv;
        logic [11:0] e_data;
        logic [3:0]  e_idx;
        logic [2:0]  e_lc;
        logic        e_full;
        logic        e_ov;
    } vec_t;

    vec_t vq[$];

    lap_capture_ctrl #(.TW(12), .DEPTH(4), .HOLD_CYCLES(100), .HOLD_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .count_en(count_en), .clear_timers(clear_timers),
        .status(status), .lap(lap), .time_in(time_in), .disp_time(disp_time),
        .disp_frozen(disp_frozen), .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_idx(rd_idx), .rd_ready(rd_ready), .lap_count(lap_count),
        .buf_full(buf_full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic clr, logic [1:0] st, logic cen, logic lp,
                                logic [11:0] tin, logic rdy, logic chk_disp,
                                logic [11:0] e_disp, logic e_frz, logic e_rv,
                                logic [11:0] e_data, logic [3:0] e_idx,
                                logic [2:0] e_lc, logic e_full, logic e_ov);
        vec_t v;
        v.clr = clr; v.st = st; v.cen = cen; v.lp = lp; v.tin = tin; v.rdy = rdy;
        v.chk_disp = chk_disp; v.e_disp = e_disp; v.e_frz = e_frz; v.e_rv = e_rv;
        v.e_data = e_data; v.e_idx = e_idx; v.e_lc = e_lc; v.e_full = e_full; v.e_ov = e_ov;
        return v;
    endfunction

    // Shorthand: running, accepted-lap style inputs
    function automatic vec_t run_lap(logic [11:0] tin, logic rdy, logic [11:0] e_disp,
                                     logic e_rv, logic [11:0] e_data, logic [3:0] e_idx,
                                     logic [2:0] e_lc, logic e_full, logic e_ov);
        return mk(1'b0, 2'b01, 1'b1, 1'b1, tin, rdy, 1'b1, e_disp, 1'b1, e_rv,
                  e_data, e_idx, e_lc, e_full, e_ov);
    endfunction

    task automatic drive(logic clr, logic [1:0] st, logic cen, logic lp,
                         logic [11:0] tin, logic rdy);
        clear_timers = clr; status = st; count_en = cen; lap = lp;
        time_in = tin; rd_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vecs();
        vec_t v;
        logic bad;
        while (vq.size() > 0) begin
            v = vq.pop_front();
            drive(v.clr, v.st, v.cen, v.lp, v.tin, v.rdy);
            bad = 1'b0;
            if (v.chk_disp && (disp_time !== v.e_disp)) bad = 1'b1;
            if (disp_frozen !== v.e_frz) bad = 1'b1;
            if (rd_valid !== v.e_rv) bad = 1'b1;
            if (v.e_rv && ((rd_data !== v.e_data) || (rd_idx !== v.e_idx))) bad = 1'b1;
            if (lap_count !== v.e_lc) bad = 1'b1;
            if (buf_full !== v.e_full) bad = 1'b1;
            if (overflow !== v.e_ov) bad = 1'b1;
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL vec%0d: got disp=%0d frz=%b rv=%b data=%0d idx=%0d lc=%0d full=%b ov=%b; expected disp=%0d frz=%b rv=%b data=%0d idx=%0d lc=%0d full=%b ov=%b",
                         vec_id, disp_time, disp_frozen, rd_valid, rd_data, rd_idx,
                         lap_count, buf_full, overflow, v.e_disp, v.e_frz, v.e_rv,
                         v.e_data, v.e_idx, v.e_lc, v.e_full, v.e_ov);
            end
            vec_id++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_timers = 1'b0; status = 2'b00; count_en = 1'b0; lap = 1'b0;
        time_in = 12'd0; rd_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_disp", 32'(disp_time), 32'd0);
        chk("reset_flags", {28'd0, disp_frozen, rd_valid, buf_full, overflow}, 32'd0);
        chk("reset_lc", 32'(lap_count), 32'd0);
        rst_n = 1'b1;

        // Ignored laps (wrong status, count_en low, clear active) then the first real lap
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 1'b1, 12'd5, 1'b0, 1'b1, 12'd5, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 12'd6, 1'b0, 1'b1, 12'd6, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 2'b01, 1'b0, 1'b1, 12'd7, 1'b0, 1'b1, 12'd7, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 2'b01, 1'b1, 1'b1, 12'd7, 1'b0, 1'b1, 12'd7, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd37, 1'b0, 12'd37, 1'b1, 12'd37, 4'd1, 3'd1, 1'b0, 1'b0));
        run_vecs();

        // Hold window: frozen for the 99 edges after capture, released on the 100th
        for (int k = 1; k <= 99; k++) begin
            drive(1'b0, 2'b01, 1'b1, 1'b0, 12'(100 + k), 1'b0);
            chk("hold1_frz", 32'(disp_frozen), 32'd1);
            chk("hold1_disp", 32'(disp_time), 32'd37);
        end
        drive(1'b0, 2'b01, 1'b1, 1'b0, 12'd200, 1'b0);
        chk("hold1_release", 32'(disp_frozen), 32'd0);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 12'd500, 1'b0);
        chk("live_track0", 32'(disp_time), 32'd500);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 12'd501, 1'b0);
        chk("live_track1", 32'(disp_time), 32'd501);

        // Drain the single lap, clear, then fill and overflow
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd502, 1'b1, 1'b1, 12'd502, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 12'd503, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd10, 1'b0, 12'd10, 1'b1, 12'd10, 4'd1, 3'd1, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd20, 1'b0, 12'd20, 1'b1, 12'd10, 4'd1, 3'd2, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd30, 1'b0, 12'd30, 1'b1, 12'd10, 4'd1, 3'd3, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd40, 1'b0, 12'd40, 1'b1, 12'd10, 4'd1, 3'd4, 1'b1, 1'b0));
        vq.push_back(run_lap(12'd50, 1'b0, 12'd50, 1'b1, 12'd10, 4'd1, 3'd4, 1'b1, 1'b1));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1, 12'd50, 1'b1, 1'b1, 12'd20, 4'd2, 3'd3, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1, 12'd50, 1'b1, 1'b1, 12'd30, 4'd3, 3'd2, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1, 12'd50, 1'b1, 1'b1, 12'd40, 4'd4, 3'd1, 1'b0, 1'b1));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1, 12'd50, 1'b1, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b1));
        // Full buffer with a simultaneous pop accepts the lap without overflow
        vq.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd10, 1'b0, 12'd10, 1'b1, 12'd10, 4'd1, 3'd1, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd20, 1'b0, 12'd20, 1'b1, 12'd10, 4'd1, 3'd2, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd30, 1'b0, 12'd30, 1'b1, 12'd10, 4'd1, 3'd3, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd40, 1'b0, 12'd40, 1'b1, 12'd10, 4'd1, 3'd4, 1'b1, 1'b0));
        vq.push_back(run_lap(12'd60, 1'b1, 12'd60, 1'b1, 12'd20, 4'd2, 3'd4, 1'b1, 1'b0));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 12'd60, 1'b1, 1'b1, 12'd30, 4'd3, 3'd3, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 12'd60, 1'b1, 1'b1, 12'd40, 4'd4, 3'd2, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 2'b10, 1'b0, 1'b0, 12'd0, 1'b1, 1'b1, 12'd60, 1'b1, 1'b1, 12'd60, 4'd5, 3'd1, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd0, 1'b1, 1'b1, 12'd60, 1'b1, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        // Clear beats a same-cycle lap and pop; ordinal restarts at 1
        vq.push_back(run_lap(12'd11, 1'b0, 12'd11, 1'b1, 12'd11, 4'd6, 3'd1, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd12, 1'b0, 12'd12, 1'b1, 12'd11, 4'd6, 3'd2, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd13, 1'b0, 12'd13, 1'b1, 12'd11, 4'd6, 3'd3, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd14, 1'b0, 12'd14, 1'b1, 12'd11, 4'd6, 3'd4, 1'b1, 1'b0));
        vq.push_back(run_lap(12'd15, 1'b0, 12'd15, 1'b1, 12'd11, 4'd6, 3'd4, 1'b1, 1'b1));
        vq.push_back(mk(1'b1, 2'b01, 1'b1, 1'b1, 12'd16, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(run_lap(12'd77, 1'b0, 12'd77, 1'b1, 12'd77, 4'd1, 3'd1, 1'b0, 1'b0));
        vq.push_back(mk(1'b1, 2'b01, 1'b1, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        vq.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 12'd3, 1'b0, 1'b1, 12'd3, 1'b0, 1'b0, 12'd0, 4'd0, 3'd0, 1'b0, 1'b0));
        run_vecs();

        // Re-lap 30 cycles into the hold restarts the full window; pausing does not shorten it
        drive(1'b0, 2'b01, 1'b1, 1'b1, 12'd5, 1'b0);
        chk("relap_first_disp", 32'(disp_time), 32'd5);
        for (int k = 1; k <= 29; k++) begin
            drive(1'b0, 2'b01, 1'b1, 1'b0, 12'(200 + k), 1'b0);
            chk("relap_hold_a", {19'd0, disp_frozen, disp_time}, {19'd0, 1'b1, 12'd5});
        end
        drive(1'b0, 2'b01, 1'b1, 1'b1, 12'd8, 1'b0);
        chk("relap_second_disp", {19'd0, disp_frozen, disp_time}, {19'd0, 1'b1, 12'd8});
        chk("relap_second_idx", {25'd0, lap_count, rd_idx}, {25'd0, 3'd2, 4'd1});
        for (int k = 1; k <= 99; k++) begin
            if (k < 50) drive(1'b0, 2'b10, 1'b0, 1'b0, 12'(300 + k), 1'b0);
            else        drive(1'b0, 2'b01, 1'b1, 1'b0, 12'(300 + k), 1'b0);
            chk("relap_hold_b", {19'd0, disp_frozen, disp_time}, {19'd0, 1'b1, 12'd8});
        end
        drive(1'b0, 2'b01, 1'b1, 1'b0, 12'd600, 1'b0);
        chk("relap_release", 32'(disp_frozen), 32'd0);
        drive(1'b0, 2'b01, 1'b1, 1'b0, 12'd601, 1'b0);
        chk("relap_live", 32'(disp_time), 32'd601);

        // Mid-run reset returns everything to its idle values
        rst_n = 1'b0;
        drive(1'b0, 2'b01, 1'b1, 1'b1, 12'd700, 1'b0);
        chk("rerst_disp", 32'(disp_time), 32'd0);
        chk("rerst_flags", {28'd0, disp_frozen, rd_valid, buf_full, overflow}, 32'd0);
        chk("rerst_lc", 32'(lap_count), 32'd0);
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lap_capture_ctrl.md
Name: lap_capture_ctrl

Overview:
Lap/split controller for the stopwatch timer datapath. It sits beside the run/pause control FSM and the timer counter. On each accepted lap request it snapshots the live timer value into a small FIFO, freezes the display on that value for a programmable hold time, and lets a downstream reader drain the recorded laps over a valid/ready handshake.

Parameters:
TW, 12, width of the timer value (time_in, disp_time, rd_data)
DEPTH, 4, lap buffer entries (power of 2, >=2)
HOLD_CYCLES, 100, cycles the display stays frozen after a lap (>=1)
HOLD_W, 16, width of the hold down-counter (must hold HOLD_CYCLES-1)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
count_en  in  1  timer counting enable from the control FSM
clear_timers  in  1  timer clear from the control FSM
status  in  2  control FSM state: 00 IDLE, 01 RUNNING, 10 PAUSED
lap  in  1  single-cycle lap request pulse (already debounced)
time_in  in  TW  live timer value
disp_time  out  TW  value to display
disp_frozen  out  1  1 = disp_time is a held lap snapshot
rd_valid  out  1  buffer holds at least one lap
rd_data  out  TW  oldest buffered lap time
rd_idx  out  4  lap ordinal of rd_data (1..15, wraps 15->1)
rd_ready  in  1  reader accepts rd_data
lap_count  out  $clog2(DEPTH)+1  number of buffered laps
buf_full  out  1  lap_count == DEPTH
overflow  out  1  sticky; a lap was dropped because the buffer was full

Behaviour:
- Reset (rst_n=0 at clk edge): state LIVE; disp_time=0, disp_frozen=0, rd_valid=0, lap_count=0, buf_full=0, overflow=0, the lap ordinal counter reads 0, and the hold counter is 0. rd_data and rd_idx are don't-care while rd_valid=0.
- Lap acceptance: a lap is accepted only when lap=1, status==01, count_en=1 and clear_timers=0. In every other case the lap is ignored and no state changes.
- Accepted lap:
  - The ordinal counter increments (15 wraps to 1, never 0).
  - If the buffer is not full, or a pop happens in the same cycle, {ordinal, time_in} is written at the tail.
  - If the buffer is full with no pop, the entry is dropped and overflow is set. The display still freezes in this case.
- Display FSM states:
  - LIVE: disp_time <= time_in every cycle (1-cycle latency); disp_frozen=0. An accepted lap loads disp_time with that cycle's time_in, sets disp_frozen=1, loads hold=HOLD_CYCLES-1, and moves to FROZEN.
  - FROZEN: disp_time is held.
    - A new accepted lap recaptures time_in and reloads hold (restart).
    - Otherwise, if hold==0, move to LIVE; disp_time tracks time_in from the next edge.
    - Otherwise, decrement hold.
  - The frozen display lasts exactly HOLD_CYCLES cycles, counted from the edge that captured the lap.
  - Pausing (status->10) does not cut the hold short.
- clear_timers=1 (sampled synchronously) has highest priority:
  - Empties the buffer, zeroes lap_count, the ordinal counter and overflow.
  - Forces state LIVE with disp_frozen=0.
  - Any lap or pop in the same cycle is discarded.
- Readout:
  - rd_valid = (lap_count != 0). rd_data/rd_idx come from the head entry, combinationally from buffer registers.
  - Pop occurs when rd_valid && rd_ready, and advances the head on that edge.
  - rd_data/rd_idx are stable while rd_valid=1 and rd_ready=0.
  - Readout is independent of status; draining is allowed in IDLE, RUNNING and PAUSED.
  - Simultaneous write and pop leaves lap_count unchanged.
  - A pop on an empty buffer is impossible (rd_valid=0).
- Pointers are $clog2(DEPTH) bits and wrap naturally. lap_count saturates logically at DEPTH (never exceeds it).
- overflow clears only on reset or clear_timers.

Test Plan:
1. Basic lap: status=01, count_en=1, time_in=37, pulse lap -> next edge disp_time=37, disp_frozen=1, lap_count=1, rd_valid=1, rd_data=37, rd_idx=1. After HOLD_CYCLES=100 cycles, disp_frozen=0 and disp_time tracks time_in with 1-cycle lag.
2. Ignored laps: lap pulsed with status=10, then with status=00 -> lap_count stays 0, disp_frozen stays 0, ordinal unchanged.
3. Fill and overflow: 5 laps at time_in=10,20,30,40,50 with rd_ready=0 -> buf_full=1, lap_count=4, overflow=1. Drain with rd_ready=1 gives (10,1),(20,2),(30,3),(40,4), then rd_valid=0; 50 is never read.
4. Full plus simultaneous pop: buffer full, lap at time_in=60 with rd_ready=1 -> head 10 popped, 60 written, lap_count stays 4, overflow stays 0.
5. Re-lap during hold: lap at t=5, second lap 30 cycles later at t=8 -> disp_time=8, and the freeze lasts 100 cycles from the second capture.
6. Clear priority: buffer holds 3 laps, frozen; assert clear_timers with lap=1 and rd_ready=1 in the same cycle -> lap_count=0, rd_valid=0, overflow=0, disp_frozen=0. The next accepted lap gets rd_idx=1.
